// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for the 3x3 Sobel window front end: tracks raster position,
// drives the line-buffer shift strobe and presents window-centre coordinates to the core.
module sobel_window_ctrl #(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100,
    parameter int CW     = $clog2(WIDTH),
    parameter int RW     = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          accept;
    logic          last_col;
    logic          new_win;

    // A pending window blocks the stream so the line buffers never move under it.
    assign busy       = (state_q == S_FILL) || (state_q == S_RUN);
    assign in_ready   = busy && (!win_valid_q || win_ready);
    assign shift_en   = in_valid && in_ready;
    assign accept     = shift_en;
    assign frame_done = (state_q == S_DONE);
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

    assign last_col = (col_q == CW'(WIDTH - 1));
    // Columns 0 and 1 would form windows wrapping across the previous line.
    assign new_win  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = new_win || (win_valid_q && !win_ready);
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_FILL, S_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        if (row_q == RW'(HEIGHT - 1)) begin
                            state_d = S_DONE;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + RW'(1);
                            if (row_q == RW'(1)) begin
                                state_d = S_RUN;
                            end
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (new_win) begin
            win_row_d = row_q - RW'(1);
            win_col_d = col_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencing controller for the two-line-buffer 3x3 window front end of the Sobel accelerator. It accepts a raster pixel stream with a valid/ready handshake and drives the shared `shift_en` of the line-buffer chain. It tracks column and row position in the frame and tells the Sobel core when the 3x3 window holds a complete interior neighbourhood, applying core backpressure to the input stream.

## Interface
- `WIDTH`, default 100: image width in pixels; must equal the line buffer `WIDTH`; minimum 3.
- `HEIGHT`, default 100: image height in lines; minimum 3.
- `CW`, default $clog2(WIDTH): column counter width.
- `RW`, default $clog2(HEIGHT): row counter width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `in_valid`  in  1  upstream pixel valid.
- `in_ready`  out  1  controller accepts a pixel this cycle.
- `shift_en`  out  1  shift strobe to every line buffer and window register; equals `in_valid & in_ready`.
- `win_valid`  out  1  window contents form a valid 3x3 neighbourhood.
- `win_ready`  in  1  Sobel core consumes the window.
- `win_row`  out  RW  row of window centre pixel.
- `win_col`  out  CW  column of window centre pixel.
- `busy`  out  1  high in FILL or RUN.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- States: IDLE, FILL (row < 2), RUN (row >= 2), DONE.
- IDLE: `in_ready`=0. `start`=1 moves to FILL and clears `col` and `row` to 0.
- Accept: a pixel is accepted when `in_valid & in_ready`. This is exactly when `shift_en` is high.
- Counters on accept:
  - col < WIDTH-1: col++.
  - col == WIDTH-1: col=0 and row++.
- FILL -> RUN: on the accept that moves row from 1 to 2.
- RUN -> DONE: on the accept of pixel (HEIGHT-1, WIDTH-1).
- DONE: `frame_done`=1 for that single cycle, then the controller returns to IDLE unconditionally.
- `start` outside IDLE is ignored.
- Window generation: an accepted pixel at (row, col) with row >= 2 and col >= 2 sets `win_valid` on the next cycle.
  - `win_row` = row-1 and `win_col` = col-1 are captured at the same edge.
  - Pixels with col < 2 or row < 2 shift data but produce no window. This suppresses windows that wrap across a line boundary.
- Windows per frame: exactly (WIDTH-2)*(HEIGHT-2), with centres in raster order from (1,1) to (HEIGHT-2, WIDTH-2).
- Backpressure: `in_ready` = (state is FILL or RUN) & (!`win_valid` | `win_ready`).
  - A pending window is never overwritten, and the line buffers never shift under a stalled window.
- `win_valid` clears when `win_valid & win_ready` and no new window is set in the same cycle.
- Simultaneous consume and new window: `win_valid` stays 1 and `win_row`/`win_col` load the new values.
- The last window of a frame may still be pending when the controller reaches DONE or IDLE. It stays valid until consumed. A new `start` is accepted regardless, because `in_ready` still gates on `win_valid`.

## Timing
- Reset values (`rst`=1 at a clock edge):
  - state = IDLE, col = 0, row = 0.
  - `in_ready`=0, `shift_en`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `busy`=0, `frame_done`=0.
- Reset mid-frame aborts immediately; no `frame_done` is issued. Line-buffer contents are not cleared by this block.
- `in_ready`, `shift_en` and `busy` are combinational from registered state and `win_valid`/`win_ready`. `in_ready` has no combinational path from `in_valid`.
- Accept-to-`win_valid` latency: 1 cycle.
- `start`-to-first `in_ready`: 1 cycle.
- Full-rate throughput: 1 pixel per cycle when `win_ready` is held at 1.
- Frame with no stalls: WIDTH*HEIGHT accept cycles.
  - `frame_done` pulses the cycle after the last accept.
  - IDLE is reached the cycle after that.

## Test plan
- WIDTH=8, HEIGHT=6, `start` pulse, `in_valid`=`win_ready`=1 continuously:
  - 48 `shift_en` cycles and 24 `win_valid` cycles.
  - First window centre (1,1) one cycle after the accept of (2,2); last window centre (4,6).
  - One `frame_done` pulse after accept 48.
- Same frame with `win_ready` low for 5 cycles while window (2,3) is pending:
  - `win_valid` held with `win_row`/`win_col` stable.
  - `in_ready` and `shift_en` are 0 for those 5 cycles.
  - Total window count is still 24.
- Line-boundary check: accepts of (3,0) and (3,1) produce no `win_valid`; the accept of (3,2) produces centre (2,1).
- `rst` asserted at accept 30:
  - All outputs are 0 the next cycle and no `frame_done` is issued.
  - A fresh `start` restarts from (0,0), and the first window again appears after accept 19.
- `start` pulsed during RUN and `in_valid` toggled 1/0 every cycle: `start` is ignored, 24 windows in order, `frame_done` once.
- Back-to-back frames with `start` high in the IDLE cycle after `frame_done`: the second frame begins with no stray window and yields 24 windows again.
